// File: rtl/prog_freq_divider.sv
// prog_freq_divider: run-time programmable synchronous clock divider.
// Divides clk_i by N (1..2^WIDTH-1). Divisor changes take effect only at a
// period boundary, or at a phase clear.
// Ports:
//   clk_i       system clock, rising edge
//   rstn_i      synchronous active-low reset
//   en_i        count enable; 0 holds count, level and divisor
//   clr_i       synchronous phase clear; applies any pending divisor
//   load_i      strobe capturing div_val_i as the pending divisor
//   div_val_i   requested divisor, 0 is treated as 1
//   q_o         divided level, high for floor(N/2) of every N cycles
//   tick_o      one-cycle pulse per completed period
//   phase_o     current count, 0..N-1
//   busy_pend_o a loaded divisor is waiting for the next boundary
module prog_freq_divider #(
  parameter int WIDTH       = 12,
  parameter int DEFAULT_DIV = 2048
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_val_i,
  output logic             q_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] phase_o,
  output logic             busy_pend_o
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt_q, cnt_d, cur_q, cur_d, pend_q, pend_d, eff;
  logic             pv_q, pv_d, q_q, q_d, tick_q, tick_d, bnd, apply;
  always_comb begin
    eff    = (div_val_i == '0) ? ONE : div_val_i;
    bnd    = en_i && (cnt_q == cur_q - ONE);
    // a clear or a boundary is the only point where the divisor may change
    apply  = clr_i || bnd;
    pend_d = load_i ? eff : pend_q;
    pv_d   = apply ? 1'b0 : (load_i || pv_q);
    // a load coinciding with the change point wins over an older pending value
    cur_d  = !apply ? cur_q : load_i ? eff : pv_q ? pend_q : cur_q;
    cnt_d  = apply ? '0 : en_i ? cnt_q + ONE : cnt_q;
    tick_d = !clr_i && bnd;
    // level taken from the next count so q and phase change on the same edge
    q_d    = clr_i ? 1'b0 : en_i ? (cnt_d >= cur_d - (cur_d >> 1)) : q_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      cur_q  <= DEF;
      pend_q <= DEF;
      pv_q   <= 1'b0;
      q_q    <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      q_q    <= q_d;
      tick_q <= tick_d;
    end
  end
  assign q_o         = q_q;
  assign tick_o      = tick_q;
  assign phase_o     = cnt_q;
  assign busy_pend_o = pv_q;
endmodule

// File: tb/tb_prog_freq_divider.sv
// tb_prog_freq_divider: vector table, directed corner sequences and random run against a reference model.
module tb_prog_freq_divider;
  localparam int W   = 12;
  localparam int DEF = 2048;
  logic         clk = 1'b0;
  logic         rstn = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         q, tick, busy;
  logic [W-1:0] phase;
  always #5 clk = ~clk;
  prog_freq_divider #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr), .load_i(load),
    .div_val_i(div_val), .q_o(q), .tick_o(tick), .phase_o(phase), .busy_pend_o(busy)
  );
  int n_chk = 0, n_fail = 0;
  int m_n = DEF, m_pos = 0;
  int pq[$];
  bit m_q = 0, m_tick = 0;
  typedef struct {
    bit r, e, c, l;
    int dv;
    bit xq, xt;
    int xp;
    bit xb;
  } vec_t;
  vec_t tbl[17];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // reference: period position plus a queue of pending requests (last one wins)
  task automatic model(input bit r, input bit e, input bit c, input bit l, input int dv);
    int ev;
    ev = (dv == 0) ? 1 : dv;
    if (!r) begin
      m_n = DEF; m_pos = 0; pq.delete(); m_tick = 0; m_q = 0;
    end else if (c) begin
      m_pos = 0; m_tick = 0; m_q = 0;
      if (l) m_n = ev;
      else if (pq.size() > 0) m_n = pq[$];
      pq.delete();
    end else if (e) begin
      if (m_pos + 1 == m_n) begin
        m_pos = 0; m_tick = 1;
        if (l) m_n = ev;
        else if (pq.size() > 0) m_n = pq[$];
        pq.delete();
      end else begin
        m_pos++; m_tick = 0;
        if (l) pq.push_back(ev);
      end
      m_q = m_pos >= (m_n + 1) / 2;
    end else begin
      m_tick = 0;
      if (l) pq.push_back(ev);
    end
  endtask
  task automatic step(input bit r, input bit e, input bit c, input bit l, input int dv);
    rstn = r; en = e; clr = c; load = l; div_val = dv[W-1:0];
    @(posedge clk);
    model(r, e, c, l, dv);
    #1;
    chk("q", q, m_q);
    chk("tick", tick, m_tick);
    chk("phase", phase, m_pos);
    chk("busy", busy, pq.size() != 0);
    @(negedge clk);
  endtask
  initial begin
    int ft, hi, k, per, bseen;
    tbl[0]  = '{0,0,0,0,0, 0,0,0,0};
    tbl[1]  = '{1,0,0,1,0, 0,0,0,1};
    tbl[2]  = '{1,0,1,0,0, 0,0,0,0};
    tbl[3]  = '{1,1,0,0,0, 0,1,0,0};
    tbl[4]  = '{1,1,0,1,3, 0,1,0,0};
    tbl[5]  = '{1,1,0,0,0, 0,0,1,0};
    tbl[6]  = '{1,1,0,0,0, 1,0,2,0};
    tbl[7]  = '{1,1,0,0,0, 0,1,0,0};
    tbl[8]  = '{1,0,0,0,0, 0,0,0,0};
    tbl[9]  = '{1,1,0,0,0, 0,0,1,0};
    tbl[10] = '{1,1,0,1,5, 1,0,2,1};
    tbl[11] = '{1,1,1,0,0, 0,0,0,0};
    tbl[12] = '{1,1,0,0,0, 0,0,1,0};
    tbl[13] = '{1,1,0,0,0, 0,0,2,0};
    tbl[14] = '{1,1,0,0,0, 1,0,3,0};
    tbl[15] = '{1,1,0,0,0, 1,0,4,0};
    tbl[16] = '{1,1,0,0,0, 0,1,0,0};
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].l, tbl[i].dv);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].xq);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].xt);
      chk($sformatf("tbl%0d_phase", i), phase, tbl[i].xp);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].xb);
    end
    // default divisor after reset, load of 4 early in the long period
    step(0, 0, 0, 0, 0);
    ft = 0; hi = 0;
    for (int i = 1; i <= 2100 && ft == 0; i++) begin
      step(1, 1, 0, i == 10, 4);
      if (i == 2047) chk("busy_before_boundary", busy, 1);
      if (q) hi++;
      if (tick) ft = i;
    end
    chk("first_tick_cycle", ft, 2048);
    chk("default_high_time", hi, 1024);
    chk("busy_after_boundary", busy, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 0, 0);
      chk("n4_phase", phase, i % 4);
      chk("n4_q", q, (i % 4) >= 2);
      chk("n4_tick", tick, (i % 4) == 0);
    end
    // N=5 with a three-cycle stall
    step(1, 0, 1, 1, 5);
    per = 0;
    for (k = 1; k <= 20 && per == 0; k++) begin
      step(1, !(k >= 3 && k <= 5), 0, 0, 0);
      if (k >= 3 && k <= 5) begin
        chk("stall_phase", phase, 2);
        chk("stall_tick", tick, 0);
      end
      if (tick) per = k;
    end
    chk("stall_period", per, 8);
    // load exactly on the boundary of N=4
    step(1, 0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("pre_boundary_phase", phase, 3);
    step(1, 1, 0, 1, 6);
    chk("boundary_load_tick", tick, 1);
    per = 0; bseen = 0;
    for (k = 1; k <= 20 && per == 0; k++) begin
      step(1, 1, 0, 0, 0);
      if (busy) bseen = 1;
      if (tick) per = k;
    end
    chk("boundary_load_period", per, 6);
    chk("boundary_load_busy", bseen, 0);
    // two loads in one period: the later one is used
    step(1, 1, 0, 1, 7);
    step(1, 1, 0, 1, 9);
    per = 0;
    for (k = 1; k <= 20 && per == 0; k++) begin
      step(1, 1, 0, 0, 0);
      if (tick) per = k;
    end
    chk("old_period_done", per, 4);
    per = 0;
    for (k = 1; k <= 20 && per == 0; k++) begin
      step(1, 1, 0, 0, 0);
      if (tick) per = k;
    end
    chk("last_load_wins", per, 9);
    // reset in the middle of an N=8 period
    step(1, 0, 1, 1, 8);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("pre_reset_phase", phase, 3);
    step(0, 1, 0, 0, 0);
    chk("reset_phase", phase, 0);
    chk("reset_q", q, 0);
    chk("reset_tick", tick, 0);
    bseen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0);
      if (tick) bseen = 1;
    end
    chk("reset_default_phase", phase, 10);
    chk("reset_no_tick", bseen, 0);
    // clear at phase 5 keeps the divisor
    step(1, 0, 1, 1, 8);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    chk("pre_clr_q", q, 1);
    step(1, 1, 1, 0, 0);
    chk("clr_phase", phase, 0);
    chk("clr_q", q, 0);
    per = 0;
    for (k = 1; k <= 20 && per == 0; k++) begin
      step(1, 1, 0, 0, 0);
      if (tick) per = k;
    end
    chk("clr_keeps_div", per, 8);
    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) != 0, ($urandom % 4) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0,
           ($urandom % 3 == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 12)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
